// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha_pkg
// Brief    : Shared state encoding, job type and mode constants for the
//            SHA chunk streamer.
// Revision : 1.0 - initial release
// ============================================================================
package sha_pkg;

    localparam int SHA256_CHUNK_BYTES = 64;
    localparam int SHA256_LEN_BYTES   = 8;
    localparam int SHA512_CHUNK_BYTES = 128;
    localparam int SHA512_LEN_BYTES   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PAD   = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } ShaStreamerState;

    typedef struct packed {
        logic [63:0]  addr;
        logic [127:0] len;
    } ShaJob;

    // Bytes that padding always adds: the 0x80 marker plus the length field.
    function automatic int mandatory_pad_bytes(input int len_bytes);
        return 1 + len_bytes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_pad_word_gen.sv
`default_nettype none
// ============================================================================
// Module   : sha_pad_word_gen
// Brief    : Combinational formatter producing one padded big-endian word of
//            the message stream from its byte offset.
// Revision : 1.0 - initial release
// ============================================================================
module sha_pad_word_gen #(
    parameter int WORD_BYTES  = 4,
    parameter int CHUNK_BYTES = 64,
    parameter int LEN_BYTES   = 8,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 64
) (
    input  logic [ADDR_W-1:0]       off,
    input  logic [ADDR_W-1:0]       msg_bytes,
    input  logic [LEN_W-1:0]        job_len,
    input  logic [WORD_BYTES*8-1:0] mem_word,
    input  logic                    final_chunk,
    output logic [WORD_BYTES*8-1:0] word
);

    localparam int CB_LOG2 = $clog2(CHUNK_BYTES);
    localparam int LB_LOG2 = $clog2(LEN_BYTES);
    localparam logic [CB_LOG2-1:0] LEN_START = CB_LOG2'(CHUNK_BYTES - LEN_BYTES);

    logic [LEN_BYTES*8-1:0] w_len_field;
    logic [7:0]             w_len_b [LEN_BYTES];

    assign w_len_field = (LEN_BYTES*8)'(job_len);

    for (genvar j = 0; j < LEN_BYTES; j++) begin : g_len
        assign w_len_b[j] = w_len_field[(LEN_BYTES-1-j)*8 +: 8];
    end

    // LEN_START is a multiple of LEN_BYTES, so the low position bits index the field directly.
    for (genvar b = 0; b < WORD_BYTES; b++) begin : g_byte
        logic [ADDR_W-1:0]  w_idx;
        logic [CB_LOG2-1:0] w_pos;
        logic [7:0]         w_byte;

        assign w_idx  = off + ADDR_W'(b);
        assign w_pos  = w_idx[CB_LOG2-1:0];
        assign w_byte = (w_idx < msg_bytes)  ? mem_word[(WORD_BYTES-1-b)*8 +: 8] :
                        (w_idx == msg_bytes) ? 8'h80 :
                        (final_chunk && (w_pos >= LEN_START)) ? w_len_b[w_pos[LB_LOG2-1:0]] :
                        8'h00;
        assign word[(WORD_BYTES-1-b)*8 +: 8] = w_byte;
    end

endmodule
`default_nettype wire

// File: rtl/sha_chunk_streamer.sv
`default_nettype none
// ============================================================================
// Module   : sha_chunk_streamer
// Brief    : Fetches a message from memory, applies SHA padding and streams
//            complete chunks to the compression core.
// Revision : 1.0 - initial release
// ============================================================================
module sha_chunk_streamer
    import sha_pkg::*;
#(
    parameter int WORD_BYTES  = 4,
    parameter int CHUNK_BYTES = SHA256_CHUNK_BYTES,
    parameter int LEN_BYTES   = SHA256_LEN_BYTES,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_vld,
    output logic                     job_rdy,
    input  logic [ADDR_W-1:0]        job_addr,
    input  logic [LEN_W-1:0]         job_len,
    output logic                     mem_req_vld,
    input  logic                     mem_req_rdy,
    output logic [ADDR_W-1:0]        mem_req_addr,
    input  logic                     mem_rsp_vld,
    input  logic [WORD_BYTES*8-1:0]  mem_rsp_data,
    output logic                     chunk_vld,
    input  logic                     chunk_rdy,
    output logic [CHUNK_BYTES*8-1:0] chunk_data,
    output logic                     chunk_last,
    output logic                     done_vld,
    output logic                     done_err,
    output logic [LEN_W-9:0]         done_nchunks
);

    localparam int WORD_W  = WORD_BYTES * 8;
    localparam int CHUNK_W = CHUNK_BYTES * 8;
    localparam int WPC     = CHUNK_BYTES / WORD_BYTES;
    localparam int IDX_W   = $clog2(WPC) + 1;
    localparam int NCH_W   = LEN_W - 8;
    localparam int PAD_MIN = mandatory_pad_bytes(LEN_BYTES);
    localparam logic [IDX_W-1:0] C_FULL = IDX_W'(WPC);

    ShaStreamerState     r_state;
    logic                r_job_rdy, r_req_vld, r_wait;
    logic                r_chunk_vld, r_chunk_last, r_done_vld, r_done_err;
    logic [ADDR_W-1:0]   r_req_addr, r_base, r_msg_bytes, r_off, r_cbase;
    logic [LEN_W-1:0]    r_len;
    logic [IDX_W-1:0]    r_widx;
    logic [CHUNK_W-1:0]  r_chunk;
    logic [NCH_W-1:0]    r_nchunks;

    logic [WORD_W-1:0]   w_word;
    logic                w_final, w_has_data, w_full;

    // A chunk is final once its end covers the message plus marker and length field.
    assign w_final    = (r_cbase + ADDR_W'(CHUNK_BYTES)) >= (r_msg_bytes + ADDR_W'(PAD_MIN));
    assign w_has_data = r_off < r_msg_bytes;
    assign w_full     = r_widx == C_FULL;

    sha_pad_word_gen #(
        .WORD_BYTES  (WORD_BYTES),
        .CHUNK_BYTES (CHUNK_BYTES),
        .LEN_BYTES   (LEN_BYTES),
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W)
    ) u_pad_word_gen (
        .off         (r_off),
        .msg_bytes   (r_msg_bytes),
        .job_len     (r_len),
        .mem_word    (mem_rsp_data),
        .final_chunk (w_final),
        .word        (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_job_rdy    <= 1'b0;
            r_req_vld    <= 1'b0;
            r_wait       <= 1'b0;
            r_chunk_vld  <= 1'b0;
            r_chunk_last <= 1'b0;
            r_done_vld   <= 1'b0;
            r_done_err   <= 1'b0;
            r_req_addr   <= '0;
            r_base       <= '0;
            r_msg_bytes  <= '0;
            r_off        <= '0;
            r_cbase      <= '0;
            r_len        <= '0;
            r_widx       <= '0;
            r_chunk      <= '0;
            r_nchunks    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_job_rdy <= 1'b1;
                    if (job_vld && r_job_rdy) begin
                        r_job_rdy   <= 1'b0;
                        r_base      <= job_addr;
                        r_len       <= job_len;
                        r_msg_bytes <= ADDR_W'(job_len >> 3);
                        r_off       <= '0;
                        r_cbase     <= '0;
                        r_widx      <= '0;
                        r_nchunks   <= '0;
                        if (job_len[2:0] != 3'd0) begin
                            r_state    <= ST_DONE;
                            r_done_vld <= 1'b1;
                            r_done_err <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_full || (!w_has_data && !r_wait && !r_req_vld)) begin
                        r_state <= ST_PAD;
                    end else if (r_wait) begin
                        if (mem_rsp_vld) begin
                            r_wait  <= 1'b0;
                            r_chunk <= {r_chunk[CHUNK_W-WORD_W-1:0], w_word};
                            r_widx  <= r_widx + IDX_W'(1);
                            r_off   <= r_off + ADDR_W'(WORD_BYTES);
                        end
                    end else if (r_req_vld) begin
                        if (mem_req_rdy) begin
                            r_req_vld <= 1'b0;
                            r_wait    <= 1'b1;
                        end
                    end else begin
                        r_req_vld  <= 1'b1;
                        r_req_addr <= r_base + r_off;
                    end
                end
                ST_PAD: begin
                    if (w_full) begin
                        r_state      <= ST_EMIT;
                        r_chunk_vld  <= 1'b1;
                        r_chunk_last <= w_final;
                    end else begin
                        r_chunk <= {r_chunk[CHUNK_W-WORD_W-1:0], w_word};
                        r_widx  <= r_widx + IDX_W'(1);
                        r_off   <= r_off + ADDR_W'(WORD_BYTES);
                    end
                end
                ST_EMIT: begin
                    if (chunk_rdy) begin
                        r_chunk_vld  <= 1'b0;
                        r_chunk_last <= 1'b0;
                        r_widx       <= '0;
                        r_cbase      <= r_off;
                        r_nchunks    <= r_nchunks + NCH_W'(1);
                        if (r_chunk_last) begin
                            r_state    <= ST_DONE;
                            r_done_vld <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_done_vld <= 1'b0;
                    r_done_err <= 1'b0;
                    r_job_rdy  <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign job_rdy      = r_job_rdy;
    assign mem_req_vld  = r_req_vld;
    assign mem_req_addr = r_req_addr;
    assign chunk_vld    = r_chunk_vld;
    assign chunk_data   = r_chunk;
    assign chunk_last   = r_chunk_last;
    assign done_vld     = r_done_vld;
    assign done_err     = r_done_err;
    assign done_nchunks = r_nchunks;

endmodule
`default_nettype wire

// File: tb/tb_sha_chunk_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_chunk_streamer
// Brief    : Scoreboard bench for sha_chunk_streamer (W4/C64/LEN8) with a
//            byte-level padding reference model and a stalling memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_chunk_streamer;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_vld, job_rdy;
    logic [31:0]  job_addr;
    logic [63:0]  job_len;
    logic         mem_req_vld, mem_req_rdy;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_vld;
    logic [31:0]  mem_rsp_data;
    logic         chunk_vld, chunk_rdy, chunk_last;
    logic [511:0] chunk_data;
    logic         done_vld, done_err;
    logic [55:0]  done_nchunks;

    always #5 clk = ~clk;

    sha_chunk_streamer #(
        .WORD_BYTES(4), .CHUNK_BYTES(64), .LEN_BYTES(8), .ADDR_W(32), .LEN_W(64)
    ) dut (
        .clk(clk), .rst(rst),
        .job_vld(job_vld), .job_rdy(job_rdy), .job_addr(job_addr), .job_len(job_len),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data),
        .chunk_vld(chunk_vld), .chunk_rdy(chunk_rdy), .chunk_data(chunk_data),
        .chunk_last(chunk_last), .done_vld(done_vld), .done_err(done_err),
        .done_nchunks(done_nchunks)
    );

    logic [7:0]   mem [0:8191];
    logic [511:0] exp_chunk_q [$];
    bit           exp_last_q  [$];
    logic [56:0]  exp_done_q  [$];
    logic [31:0]  exp_req_q   [$];
    logic [511:0] last_chunk;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int jobs_issued = 0;
    bit mem_stall = 0;
    int chunk_bp  = 0;
    int hold_cnt  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got an unexpected event, expected none", name);
    endtask

    // Reference: build the padded byte stream directly from the padding rules.
    task automatic push_expect(input logic [31:0] addr, input logic [63:0] len_bits);
        int           msg_len;
        int           n;
        int           i;
        logic [7:0]   v;
        logic [511:0] d;
        msg_len = int'(len_bits >> 3);
        if (len_bits[2:0] != 3'd0) begin
            exp_done_q.push_back({1'b1, 56'd0});
            return;
        end
        n = (msg_len + 1 + 8 + 63) / 64;
        for (int c = 0; c < n; c++) begin
            d = '0;
            for (int j = 0; j < 64; j++) begin
                i = c * 64 + j;
                if (i < msg_len)                v = mem[addr + 32'(i)];
                else if (i == msg_len)          v = 8'h80;
                else if (i >= n * 64 - 8)       v = 8'(len_bits >> (8 * (n * 64 - 1 - i)));
                else                            v = 8'h00;
                d[511 - 8 * j -: 8] = v;
            end
            exp_chunk_q.push_back(d);
            exp_last_q.push_back(c == n - 1);
        end
        for (int k = 0; k < (msg_len + 3) / 4; k++)
            exp_req_q.push_back(addr + 32'(4 * k));
        exp_done_q.push_back({1'b0, 56'(n)});
    endtask

    task automatic send_job(input logic [31:0] a, input logic [63:0] l);
        int t;
        t = 0;
        job_addr = a;
        job_len  = l;
        job_vld  = 1'b1;
        @(negedge clk);
        while (!job_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("job_accept_timeout", job_rdy, 1'b1);
        @(posedge clk);
        #1 job_vld = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] a, input logic [63:0] l);
        int t;
        push_expect(a, l);
        send_job(a, l);
        jobs_issued++;
        t = 0;
        while (done_cnt < jobs_issued && t < 20000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("done_timeout", done_cnt, jobs_issued);
    endtask

    // Memory: one outstanding read, optional accept stalls and response delay.
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] a;
        pend = 0; cnt = 0; a = '0;
        mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
            end else if (mem_req_vld && mem_req_rdy) begin
                pend = 1;
                a    = mem_req_addr;
                cnt  = mem_stall ? int'($urandom_range(0, 3)) : 0;
            end
            @(posedge clk);
            #1;
            mem_rsp_vld = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    mem_rsp_vld  = 1'b1;
                    mem_rsp_data = {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            mem_req_rdy = mem_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        chunk_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (chunk_bp == 0) begin
                chunk_rdy = 1'b1;
            end else if (chunk_bp == 1) begin
                chunk_rdy = ($urandom_range(0, 2) == 0);
            end else if (chunk_vld && hold_cnt < 10) begin
                chunk_rdy = 1'b0;
                hold_cnt++;
            end else begin
                chunk_rdy = chunk_vld;
                hold_cnt  = 0;
            end
        end
    end

    // Monitor: compares every output event against the scoreboard queues.
    initial begin
        bit           chunk_hold, req_hold;
        logic [511:0] prev_data;
        logic         prev_last;
        logic [31:0]  prev_addr;
        logic [56:0]  d;
        chunk_hold = 0; req_hold = 0; prev_data = '0; prev_last = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chunk_hold = 0;
                req_hold   = 0;
            end else begin
                if (chunk_hold) begin
                    chk("chunk_vld_held", chunk_vld, 1'b1);
                    chk("chunk_data_stable", chunk_data, prev_data);
                    chk("chunk_last_stable", chunk_last, prev_last);
                end
                if (req_hold) begin
                    chk("req_vld_held", mem_req_vld, 1'b1);
                    chk("req_addr_stable", mem_req_addr, prev_addr);
                end
                if (chunk_vld && chunk_rdy) begin
                    if (exp_chunk_q.size() == 0) begin
                        fail_event("chunk");
                    end else begin
                        chk("chunk_data", chunk_data, exp_chunk_q.pop_front());
                        chk("chunk_last", chunk_last, exp_last_q.pop_front());
                    end
                    last_chunk = chunk_data;
                end
                if (mem_req_vld && mem_req_rdy) begin
                    if (exp_req_q.size() == 0) fail_event("mem_req");
                    else chk("mem_req_addr", mem_req_addr, exp_req_q.pop_front());
                end
                if (done_vld) begin
                    if (exp_done_q.size() == 0) begin
                        fail_event("done");
                    end else begin
                        d = exp_done_q.pop_front();
                        chk("done_err", done_err, d[56]);
                        chk("done_nchunks", done_nchunks, d[55:0]);
                    end
                    chk("reqs_outstanding_at_done", exp_req_q.size(), 0);
                    chk("chunks_outstanding_at_done", exp_chunk_q.size(), 0);
                    done_cnt++;
                end
                chunk_hold = chunk_vld && !chunk_rdy;
                req_hold   = mem_req_vld && !mem_req_rdy;
                prev_data  = chunk_data;
                prev_last  = chunk_last;
                prev_addr  = mem_req_addr;
            end
        end
    end

    initial begin
        int          msg_len;
        logic [31:0] a;
        logic [63:0] l;
        rst = 1'b1; job_vld = 1'b0; job_addr = '0; job_len = '0;
        last_chunk = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_job_rdy", job_rdy, 1'b0);
        chk("rst_mem_req_vld", mem_req_vld, 1'b0);
        chk("rst_chunk_vld", chunk_vld, 1'b0);
        chk("rst_chunk_last", chunk_last, 1'b0);
        chk("rst_done_vld", done_vld, 1'b0);
        chk("rst_done_err", done_err, 1'b0);
        chk("rst_chunk_data", chunk_data, '0);
        chk("rst_done_nchunks", done_nchunks, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        mem[100] = 8'h61; mem[101] = 8'h62; mem[102] = 8'h63;
        run_job(32'd100, 64'd24);
        chk("abc_word0", last_chunk[511:480], 32'h61626380);
        chk("abc_word15", last_chunk[31:0], 32'h00000018);

        run_job(32'd200, 64'd0);
        chk("len0_word0", last_chunk[511:480], 32'h80000000);
        chk("len0_rest", last_chunk[479:0], '0);

        run_job(32'd0, 64'd440);
        run_job(32'd300, 64'd448);
        chk("l56_c1_words0_13", last_chunk[511:64], '0);
        chk("l56_c1_word15", last_chunk[31:0], 32'h000001C0);

        run_job(32'd0, 64'd13);

        chunk_bp = 2; mem_stall = 1;
        run_job(32'd400, 64'(130 * 8));
        chunk_bp = 0; mem_stall = 0;

        // Abort a job in FETCH and confirm the next job is unaffected.
        push_expect(32'd1000, 64'(200 * 8));
        send_job(32'd1000, 64'(200 * 8));
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        exp_chunk_q.delete(); exp_last_q.delete(); exp_done_q.delete(); exp_req_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_mem_req_vld", mem_req_vld, 1'b0);
        chk("midrst_chunk_vld", chunk_vld, 1'b0);
        chk("midrst_job_rdy", job_rdy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_idle_job_rdy", job_rdy, 1'b1);
        @(posedge clk);
        #1;
        run_job(32'd1000, 64'(70 * 8));

        for (int j = 0; j < 20; j++) begin
            mem_stall = (j % 2) == 1;
            chunk_bp  = (j % 3 == 0) ? 1 : 0;
            a = 32'($urandom_range(0, 1000)) * 32'd4;
            msg_len = int'($urandom_range(0, 300));
            l = 64'(msg_len) * 64'd8;
            if (j % 7 == 3) l = l + 64'($urandom_range(1, 7));
            run_job(a, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
